wb_regfile_scb: RTL and testbench
=================================

Name: wb_regfile_scb

Overview:
- Writeback-side consumer of the MEM/WB pipeline register outputs.
- Selects the writeback result, commits it to an 8x32 scalar register file, and returns the result to the PC mux.
- Serves the two decode read ports with a write-first bypass.
- Holds a per-register busy scoreboard that raises a decode stall on RAW/WAW hazards against in-flight writes.

Parameters:
- NREG, 8, number of architectural registers (address width = clog2(NREG) = 3).
- DW, 32, data width.

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- PCSrcW  in  1  writeback instruction redirects PC
- RegWriteW  in  1  writeback instruction writes a register
- MemtoRegW  in  1  1: ReadDataW is the result, 0: ALUOutW is the result
- ReadDataW  in  32  memory load data
- ALUOutW  in  32  ALU result
- WA3W  in  3  writeback destination register
- RA1D  in  3  decode read address 1
- RA2D  in  3  decode read address 2
- IssueD  in  1  decode instruction leaves decode this cycle if not stalled
- IssueWrD  in  1  issuing instruction will write a register
- WA3D  in  3  issuing instruction destination
- FlushScb  in  1  pipeline flush; clears all busy bits
- RD1D  out  32  read data 1
- RD2D  out  32  read data 2
- ResultW  out  32  selected writeback result
- PCWriteW  out  1  equals PCSrcW (PC load enable)
- StallD  out  1  decode must hold
- BusyMask  out  8  scoreboard state, for debug/verification

Behaviour:
- Result selection:
  - ResultW = MemtoRegW ? ReadDataW : ALUOutW. Combinational, zero latency.
  - PCWriteW = PCSrcW.
- Register file:
  - 8 entries x 32 bits. All registers are ordinary; r0 is not hardwired.
  - On a posedge with rst=0 and RegWriteW=1: regs[WA3W] <= ResultW.
- Reads:
  - Combinational, write-first bypass.
  - RDnD = (RegWriteW && WA3W==RAnD) ? ResultW : regs[RAnD].
  - Both ports may read the same address, and may bypass simultaneously.
- Scoreboard:
  - busy[7:0]; BusyMask = busy.
  - clr_hit(r) = RegWriteW && WA3W==r.
  - eff_busy(r) = busy[r] && !clr_hit(r).
- Stall:
  - StallD = IssueD && ( eff_busy(RA1D) || eff_busy(RA2D) || (IssueWrD && eff_busy(WA3D)) ).
  - Reads of a non-busy register never stall, even if unused by the instruction; decode gates unused ports via IssueD.
- Next busy, per register r, evaluated in priority order:
  1. rst -> 0
  2. FlushScb -> 0 (overrides a same-cycle issue)
  3. issue-set: IssueD && !StallD && IssueWrD && WA3D==r -> 1 (wins over a same-cycle clear of the same r)
  4. clr_hit(r) -> 0
  5. otherwise hold
- Writeback to a register whose busy bit is 0 still writes regs; the clear is a no-op.
- Reset:
  - All regs = 0 and busy = 0 on the first posedge with rst=1.
  - With rst held, outputs follow the combinational rules: RD1D/RD2D read 0 unless bypassed; StallD=0.
  - Reset mid-operation discards all pending busy state; in-flight writes arriving after reset still write regs.
- Each register's busy bit is single-bit; a WAW stall guarantees at most one outstanding write per register.
- No X propagation: all address inputs are fully decoded (8 entries, 3 bits).

Test Plan:
- Reset, then write r3=0xDEADBEEF via RegWriteW=1, MemtoRegW=0, ALUOutW=0xDEADBEEF -> next cycle RA1D=3 reads 0xDEADBEEF; ResultW=0xDEADBEEF during the write cycle.
- Bypass: in the same cycle as a RegWriteW write of r5=0x12345678 from ReadDataW with MemtoRegW=1, set RA1D=RA2D=5 -> RD1D=RD2D=0x12345678 combinationally.
- RAW stall:
  - Issue a write to r2 (IssueD=1, IssueWrD=1, WA3D=2) -> busy=0x04.
  - Next instruction with RA2D=2 -> StallD=1 each cycle until the r2 writeback cycle.
  - In that cycle StallD=0 and RD2D shows the bypassed value.
  - The following cycle busy=0x00.
- Simultaneous clear and set on r4: writeback of r4 while a new r4 writer issues unstalled -> busy[4]=1 afterwards.
- WAW stall: r6 busy, issue with IssueWrD=1, WA3D=6 -> StallD=1 and busy unchanged.
- Flush and mid-operation reset:
  - busy=0x0F and FlushScb=1 with a same-cycle issue to r7 -> busy=0x00.
  - Assert rst with busy=0xFF and r1=0x55 -> next cycle busy=0x00 and r1 reads 0.

Source files
------------

// File: rtl/wb_regfile_scb.sv
// Writeback stage: result select, 8x32 register file with write-first bypass,
// and a per-register busy scoreboard that stalls decode on RAW/WAW hazards.
module wb_regfile_scb #(
  parameter int NREG = 8,
  parameter int DW   = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     PCSrcW,
  input  logic                     RegWriteW,
  input  logic                     MemtoRegW,
  input  logic [DW-1:0]            ReadDataW,
  input  logic [DW-1:0]            ALUOutW,
  input  logic [$clog2(NREG)-1:0]  WA3W,
  input  logic [$clog2(NREG)-1:0]  RA1D,
  input  logic [$clog2(NREG)-1:0]  RA2D,
  input  logic                     IssueD,
  input  logic                     IssueWrD,
  input  logic [$clog2(NREG)-1:0]  WA3D,
  input  logic                     FlushScb,
  output logic [DW-1:0]            RD1D,
  output logic [DW-1:0]            RD2D,
  output logic [DW-1:0]            ResultW,
  output logic                     PCWriteW,
  output logic                     StallD,
  output logic [NREG-1:0]          BusyMask
);

  localparam int AW = $clog2(NREG);

  logic [DW-1:0]   r_regs [NREG];
  logic [NREG-1:0] r_busy;

  logic [DW-1:0]   w_result;
  logic [NREG-1:0] w_clr;
  logic [NREG-1:0] w_eff_busy;
  logic [NREG-1:0] w_set;
  logic            w_stall;
  logic            w_byp1;
  logic            w_byp2;

  assign w_result = MemtoRegW ? ReadDataW : ALUOutW;
  assign ResultW  = w_result;
  assign PCWriteW = PCSrcW;

  assign w_byp1 = RegWriteW && (WA3W == RA1D);
  assign w_byp2 = RegWriteW && (WA3W == RA2D);
  assign RD1D   = w_byp1 ? w_result : r_regs[RA1D];
  assign RD2D   = w_byp2 ? w_result : r_regs[RA2D];

  // A register whose writeback lands this cycle is already free for decode.
  always_comb begin
    w_clr      = '0;
    w_eff_busy = '0;
    for (int i = 0; i < NREG; i++) begin
      w_clr[i]      = RegWriteW && (WA3W == AW'(i));
      w_eff_busy[i] = r_busy[i] && !w_clr[i];
    end
  end

  assign w_stall = IssueD && (w_eff_busy[RA1D] || w_eff_busy[RA2D] ||
                              (IssueWrD && w_eff_busy[WA3D]));
  assign StallD  = w_stall;

  always_comb begin
    w_set = '0;
    for (int i = 0; i < NREG; i++)
      w_set[i] = IssueD && !w_stall && IssueWrD && (WA3D == AW'(i));
  end

  assign BusyMask = r_busy;

  // New issue wins over a same-cycle clear; flush wins over both.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) r_regs[i] <= '0;
      r_busy <= '0;
    end else begin
      if (RegWriteW) r_regs[WA3W] <= w_result;
      if (FlushScb) r_busy <= '0;
      else          r_busy <= (r_busy & ~w_clr) | w_set;
    end
  end

endmodule

// File: tb/tb_wb_regfile_scb.sv
// Scoreboard bench for wb_regfile_scb: directed hazard scenarios plus a
// randomized phase, all checked against a reference model.
module tb_wb_regfile_scb;

  logic        clk = 1'b0;
  logic        rst;
  logic        PCSrcW, RegWriteW, MemtoRegW;
  logic [31:0] ReadDataW, ALUOutW;
  logic [2:0]  WA3W, RA1D, RA2D, WA3D;
  logic        IssueD, IssueWrD, FlushScb;
  logic [31:0] RD1D, RD2D, ResultW;
  logic        PCWriteW, StallD;
  logic [7:0]  BusyMask;

  wb_regfile_scb #(.NREG(8), .DW(32)) dut (
    .clk(clk), .rst(rst), .PCSrcW(PCSrcW), .RegWriteW(RegWriteW),
    .MemtoRegW(MemtoRegW), .ReadDataW(ReadDataW), .ALUOutW(ALUOutW),
    .WA3W(WA3W), .RA1D(RA1D), .RA2D(RA2D), .IssueD(IssueD),
    .IssueWrD(IssueWrD), .WA3D(WA3D), .FlushScb(FlushScb),
    .RD1D(RD1D), .RD2D(RD2D), .ResultW(ResultW), .PCWriteW(PCWriteW),
    .StallD(StallD), .BusyMask(BusyMask)
  );

  always #5 clk = ~clk;

  localparam int SEL_RD1 = 0, SEL_RD2 = 1, SEL_RES = 2, SEL_PCW = 3,
                 SEL_STALL = 4, SEL_BUSY = 5;

  typedef struct {
    string       tag;
    int          sel;
    logic [31:0] exp;
  } exp_t;

  exp_t        sb_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;

  logic [31:0] m_regs [8];
  logic [7:0]  m_busy;
  bit          m_init = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic push(input string tag, input int sel, input logic [31:0] exp);
    exp_t e;
    e.tag = tag; e.sel = sel; e.exp = exp;
    sb_q.push_back(e);
  endtask

  function automatic logic [31:0] observe(input int sel);
    case (sel)
      SEL_RD1:   return RD1D;
      SEL_RD2:   return RD2D;
      SEL_RES:   return ResultW;
      SEL_PCW:   return {31'b0, PCWriteW};
      SEL_STALL: return {31'b0, StallD};
      default:   return {24'b0, BusyMask};
    endcase
  endfunction

  task automatic drain();
    exp_t e;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check(e.tag, observe(e.sel), e.exp);
    end
  endtask

  function automatic logic [31:0] m_res();
    return MemtoRegW ? ReadDataW : ALUOutW;
  endfunction

  function automatic bit m_eff(input logic [2:0] r);
    return m_busy[r] && !(RegWriteW && WA3W == r);
  endfunction

  function automatic bit m_stall();
    return IssueD && (m_eff(RA1D) || m_eff(RA2D) || (IssueWrD && m_eff(WA3D)));
  endfunction

  task automatic model_expect();
    if (m_init) begin
      push("m_rd1", SEL_RD1, (RegWriteW && WA3W == RA1D) ? m_res() : m_regs[RA1D]);
      push("m_rd2", SEL_RD2, (RegWriteW && WA3W == RA2D) ? m_res() : m_regs[RA2D]);
      push("m_stall", SEL_STALL, {31'b0, m_stall()});
      push("m_busy", SEL_BUSY, {24'b0, m_busy});
    end
    push("m_res", SEL_RES, m_res());
    push("m_pcw", SEL_PCW, {31'b0, PCSrcW});
  endtask

  task automatic model_update();
    logic [7:0] nb;
    bit         st;
    st = m_stall();
    if (rst) begin
      for (int i = 0; i < 8; i++) m_regs[i] = '0;
      m_busy = '0;
      m_init = 1'b1;
    end else if (m_init) begin
      nb = m_busy;
      if (FlushScb) nb = '0;
      else begin
        if (RegWriteW) nb[WA3W] = 1'b0;
        if (IssueD && !st && IssueWrD) nb[WA3D] = 1'b1;
      end
      if (RegWriteW) m_regs[WA3W] = m_res();
      m_busy = nb;
    end
  endtask

  // Inputs are set just after a falling edge; outputs sampled 1 time unit later.
  task automatic cycle();
    #1;
    model_expect();
    drain();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic idle();
    rst = 0; PCSrcW = 0; RegWriteW = 0; MemtoRegW = 0; ReadDataW = '0; ALUOutW = '0;
    WA3W = 0; RA1D = 0; RA2D = 0; IssueD = 0; IssueWrD = 0; WA3D = 0; FlushScb = 0;
  endtask

  task automatic issue_wr(input logic [2:0] dst, input logic [2:0] ra);
    idle();
    IssueD = 1; IssueWrD = 1; WA3D = dst; RA1D = ra; RA2D = ra;
    cycle();
  endtask

  initial begin
    idle();
    rst = 1;
    @(negedge clk);
    cycle();
    rst = 1;
    push("rst_busy", SEL_BUSY, 32'h0);
    push("rst_stall", SEL_STALL, 32'h0);
    push("rst_rd1", SEL_RD1, 32'h0);
    cycle();

    // Write r3 through ALU path, then read it back.
    idle();
    RegWriteW = 1; ALUOutW = 32'hDEADBEEF; ReadDataW = 32'h11111111; WA3W = 3; PCSrcW = 1;
    push("wr_result", SEL_RES, 32'hDEADBEEF);
    push("pcwrite", SEL_PCW, 32'h1);
    cycle();
    idle(); RA1D = 3;
    push("r3_read", SEL_RD1, 32'hDEADBEEF);
    cycle();

    // Dual-port bypass from load data.
    idle();
    RegWriteW = 1; MemtoRegW = 1; ReadDataW = 32'h12345678; ALUOutW = 32'hCAFEF00D;
    WA3W = 5; RA1D = 5; RA2D = 5;
    push("byp_rd1", SEL_RD1, 32'h12345678);
    push("byp_rd2", SEL_RD2, 32'h12345678);
    cycle();

    // RAW stall on r2 until its writeback.
    issue_wr(3'd2, 3'd0);
    idle(); IssueD = 1; RA2D = 2;
    push("raw_busy", SEL_BUSY, 32'h04);
    for (int i = 0; i < 3; i++) begin
      push("raw_stall", SEL_STALL, 32'h1);
      cycle();
    end
    RegWriteW = 1; WA3W = 2; ALUOutW = 32'hA5A50002;
    push("raw_release", SEL_STALL, 32'h0);
    push("raw_bypass", SEL_RD2, 32'hA5A50002);
    cycle();
    idle();
    push("raw_clear", SEL_BUSY, 32'h00);
    cycle();

    // Same-cycle clear and set of r4: set wins.
    issue_wr(3'd4, 3'd0);
    idle();
    RegWriteW = 1; WA3W = 4; ALUOutW = 32'h44444444;
    IssueD = 1; IssueWrD = 1; WA3D = 4;
    push("cs_nostall", SEL_STALL, 32'h0);
    cycle();
    idle();
    push("cs_busy", SEL_BUSY, 32'h10);
    cycle();

    // WAW stall on r6 leaves busy unchanged.
    issue_wr(3'd6, 3'd0);
    idle(); IssueD = 1; IssueWrD = 1; WA3D = 6;
    push("waw_stall", SEL_STALL, 32'h1);
    cycle();
    idle();
    push("waw_busy", SEL_BUSY, 32'h50);
    cycle();

    // Flush overrides a same-cycle issue.
    idle(); FlushScb = 1;
    cycle();
    for (int i = 0; i < 4; i++) issue_wr(3'(i), 3'd7);
    idle(); FlushScb = 1; IssueD = 1; IssueWrD = 1; WA3D = 7; RA1D = 7; RA2D = 7;
    push("fl_pre", SEL_BUSY, 32'h0F);
    cycle();
    idle();
    push("fl_busy", SEL_BUSY, 32'h00);
    cycle();

    // Mid-operation reset with everything busy.
    idle(); RegWriteW = 1; WA3W = 1; ALUOutW = 32'h55;
    cycle();
    for (int i = 0; i < 8; i++) issue_wr(3'(i), 3'd7);
    idle(); RA1D = 1;
    push("mr_pre_busy", SEL_BUSY, 32'hFF);
    push("mr_pre_r1", SEL_RD1, 32'h55);
    rst = 1;
    cycle();
    idle(); RA1D = 1;
    push("mr_busy", SEL_BUSY, 32'h00);
    push("mr_r1", SEL_RD1, 32'h0);
    cycle();

    // Randomized traffic against the model.
    for (int n = 0; n < 400; n++) begin
      rst       = ($urandom_range(0, 99) == 0);
      FlushScb  = ($urandom_range(0, 39) == 0);
      PCSrcW    = 1'($urandom);
      RegWriteW = ($urandom_range(0, 2) != 0);
      MemtoRegW = 1'($urandom);
      ReadDataW = $urandom;
      ALUOutW   = $urandom;
      WA3W      = 3'($urandom);
      RA1D      = 3'($urandom);
      RA2D      = 3'($urandom);
      IssueD    = 1'($urandom);
      IssueWrD  = 1'($urandom);
      WA3D      = 3'($urandom);
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
